// File: rtl/matrix_frame_scroller.sv
//------------------------------------------------------------------------------
// Module  : matrix_frame_scroller
// Brief   : Double-buffered 8x8 frame source with tear-free swap and wrap scroll.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_frame_scroller #(
  parameter int SCROLL_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [7:0]  i_wdata,
  input  logic        i_swap,
  input  logic        i_scroll_en,
  input  logic        i_scroll_dir,
  output logic [63:0] o_seq,
  output logic        o_busy,
  output logic        o_frame_tick
);

  localparam logic [7:0] c_DIV_M1 = 8'(SCROLL_DIV - 1);

  logic [7:0][7:0] r_back;
  logic [7:0][7:0] r_front;
  logic [2:0]      r_phase;
  logic [2:0]      r_offset;
  logic [7:0]      r_frame_cnt;
  logic            r_pending;
  logic            r_tick;
  logic            w_fb;

  // Frame boundary: last column of the scan driver is being consumed.
  assign w_fb = i_ce && (r_phase == 3'd7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_back <= '0;
    end else if (i_we) begin
      r_back[i_waddr] <= i_wdata;
    end
  end

  // Front takes the pre-write back content when a write hits the swap edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_front <= '0;
    end else if (w_fb && r_pending) begin
      r_front <= r_back;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= 3'd0;
      r_offset    <= 3'd0;
      r_frame_cnt <= 8'd0;
      r_pending   <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= w_fb;
      if (i_ce) begin
        r_phase <= r_phase + 3'd1;
      end
      if (w_fb && r_pending) begin
        r_pending   <= 1'b0;
        r_offset    <= 3'd0;
        r_frame_cnt <= 8'd0;
      end else begin
        if (i_swap) begin
          r_pending <= 1'b1;
        end
        if (i_ce && !i_scroll_en) begin
          r_frame_cnt <= 8'd0;
        end else if (w_fb) begin
          if (r_frame_cnt == c_DIV_M1) begin
            r_frame_cnt <= 8'd0;
            r_offset    <= i_scroll_dir ? (r_offset - 3'd1) : (r_offset + 3'd1);
          end else begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end
        end
      end
    end
  end

  // Each row byte is rotated left by the scroll offset.
  for (genvar r = 0; r < 8; r++) begin : g_row
    logic [15:0] w_dbl;
    assign w_dbl = {r_front[r], r_front[r]} << r_offset;
    assign o_seq[63-8*r -: 8] = w_dbl[15:8];
  end

  assign o_busy       = r_pending;
  assign o_frame_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_scroller.sv
//------------------------------------------------------------------------------
// Module  : tb_matrix_frame_scroller
// Brief   : Self-checking bench for matrix_frame_scroller against a frame-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_frame_scroller;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, we, swap, en, dir;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic [63:0] seq;
  logic        busy, tick;

  int checks = 0;
  int errors = 0;

  bit [7:0] m_back  [8];
  bit [7:0] m_front [8];
  int       m_phase, m_off, m_fcnt;
  bit       m_pend, m_tick;

  matrix_frame_scroller #(.SCROLL_DIV(DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_swap(swap), .i_scroll_en(en), .i_scroll_dir(dir),
    .o_seq(seq), .o_busy(busy), .o_frame_tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_back[i] = 8'h00;
      m_front[i] = 8'h00;
    end
    m_phase = 0; m_off = 0; m_fcnt = 0; m_pend = 0; m_tick = 0;
  endtask

  // Displayed column c of row r shows front column (c+offset) mod 8.
  function automatic logic [63:0] exp_seq();
    logic [63:0] e = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        e[63-8*r-c] = m_front[r][7-((c+m_off)%8)];
    return e;
  endfunction

  task automatic cyc(input bit c, input bit w, input int wa, input bit [7:0] wd, input bit sw);
    bit fb;
    ce = c; we = w; waddr = 3'(wa); wdata = wd; swap = sw;
    fb = c && (m_phase == 7);
    m_tick = fb;
    if (fb && m_pend) begin
      m_front = m_back;
      m_off = 0; m_fcnt = 0; m_pend = 0;
    end else begin
      if (c && !en) m_fcnt = 0;
      else if (fb) begin
        m_fcnt++;
        if (m_fcnt == DIV) begin
          m_fcnt = 0;
          m_off = dir ? (m_off + 7) % 8 : (m_off + 1) % 8;
        end
      end
      if (sw) m_pend = 1;
    end
    if (c) m_phase = (m_phase + 1) % 8;
    if (w) m_back[wa] = wd;
    @(posedge clk);
    #1;
    ce = 0; we = 0; swap = 0;
    chk("seq", seq, exp_seq());
    chk("busy", 64'(busy), 64'(m_pend));
    chk("tick", 64'(tick), 64'(m_tick));
  endtask

  task automatic frames(input int n);
    repeat (n * 8) cyc(1, 0, 0, 8'h00, 0);
  endtask

  task automatic swap_and_wait(input string tag);
    bit got = 0;
    cyc(1, 0, 0, 8'h00, 1);
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(1, 0, 0, 8'h00, 0);
      got = tick;
    end
    chk({tag, "_tick_seen"}, 64'(got), 64'd1);
  endtask

  initial begin
    int t_last, gap, nt;
    rst_n = 0; ce = 0; we = 0; swap = 0; en = 0; dir = 0; waddr = 0; wdata = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_seq", seq, 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    rst_n = 1;

    // Diagonal image, swap with continuous CE.
    for (int r = 0; r < 8; r++) cyc(0, 1, r, 8'h80 >> r, 0);
    chk("pre_swap_seq", seq, 64'h0);
    swap_and_wait("diag");
    chk("diag_seq", seq, 64'h8040201008040201);
    chk("diag_busy", 64'(busy), 64'd0);

    // Single pixel, left scroll.
    cyc(0, 1, 0, 8'h80, 0);
    for (int r = 1; r < 8; r++) cyc(0, 1, r, 8'h00, 0);
    swap_and_wait("px");
    en = 1; dir = 0;
    frames(4);  chk("left4", 64'(seq[63:56]), 64'h01);
    frames(4);  chk("left8", 64'(seq[63:56]), 64'h02);
    frames(24); chk("left32", 64'(seq[63:56]), 64'h80);

    // Right scroll, then hold.
    en = 0;
    swap_and_wait("px2");
    en = 1; dir = 1;
    frames(4);  chk("right4", 64'(seq[63:56]), 64'h40);
    en = 0;
    frames(20); chk("hold20", 64'(seq[63:56]), 64'h40);

    // Swap requested on a boundary is deferred; coincident scroll step is overridden.
    cyc(0, 1, 0, 8'hC0, 0);
    en = 1; dir = 0;
    frames(2);
    repeat (7) cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 1);
    chk("defer_busy", 64'(busy), 64'd1);
    chk("defer_row0", 64'(seq[63:56]), 64'h40);
    frames(1);
    chk("swap_wins", seq, {8'hC0, 56'h0});
    chk("swap_wins_busy", 64'(busy), 64'd0);

    // CE 1-in-3: boundary every 24 clocks; writes with CE=0 still land.
    en = 0;
    t_last = -1; gap = 0; nt = 0;
    for (int k = 0; k < 80; k++) begin
      cyc((k % 3) == 0, (k % 3) == 1, k % 8, 8'(k), 0);
      if (tick) begin
        if (t_last >= 0) begin
          chk("ce_gap", 64'(k - t_last), 64'd24);
          gap++;
        end
        t_last = k; nt++;
      end
    end
    chk("ce_gaps_seen", 64'(gap >= 2), 64'd1);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      bit c;
      if ((k % 60) == 0) begin
        en = 1'($urandom_range(0, 1));
        dir = 1'($urandom_range(0, 1));
      end
      c = 1'($urandom_range(0, 1));
      cyc(c, ($urandom % 4) == 0, $urandom_range(0, 7), 8'($urandom),
          c && (($urandom % 12) == 0));
    end

    // Asynchronous reset with a swap pending.
    for (int k = 0; k < 3 && !m_pend; k++) cyc(1, 0, 0, 8'h00, 1);
    chk("pend_before_rst", 64'(busy), 64'd1);
    rst_n = 0;
    model_reset();
    #1;
    chk("arst_seq", seq, 64'h0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_tick", 64'(tick), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (16) cyc(1, 0, 0, 8'h00, 0);
    chk("post_rst_seq", seq, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
